// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, the frame
// marker, word capacity and the instruction word type.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MAX_WORDS = 64;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    RUN,
    ERROR
  } state_t;

  // States in which the loader takes a byte from upstream.
  function automatic logic accepts_bytes(input state_t s);
    return (s == IDLE) || (s == COUNT) || (s == DATA) ||
           (s == CHECK) || (s == ERROR);
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == COUNT) || (s == DATA) || (s == WRITE) || (s == CHECK);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The loader is the slave of the stream and drives the memory write port.
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready,
    input  mem_wen,
    input  mem_addr,
    input  mem_data
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready,
    output mem_wen,
    output mem_addr,
    output mem_data
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs four big-endian bytes into one instruction word; word_done flags the
// cycle in which the fourth byte of a group is being shifted in.
module byte_packer
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       clear,
  input  logic       shift_en,
  input  logic [7:0] in_byte,
  output word_t      word,
  output logic       word_done
);

  word_t      word_q, word_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = {word_q[23:0], in_byte};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word      = word_q;
  assign word_done = shift_en && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Frame-driven instruction loader: unpacks a checksummed byte stream into
// instruction memory and releases the processor once the frame verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            clr,
  program_loader_if.slave bus,
  output logic            cpu_run,
  output logic            load_busy,
  output logic            load_error,
  output logic [6:0]      words_loaded
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        chk_q, chk_d;
  logic [6:0]        count_q, count_d;
  logic [6:0]        words_q, words_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;

  logic              accept;
  logic              pk_clear;
  logic              pk_shift;
  logic              pk_done;
  word_t             pk_word;

  // in_ready is the only unregistered output; gating with clr keeps it low in reset.
  assign bus.in_ready = clr & accepts_bytes(state_q);
  assign accept       = bus.in_valid & bus.in_ready;

  byte_packer u_packer (
    .clk       (clk),
    .clr       (clr),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .in_byte   (bus.in_byte),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    chk_d    = chk_q;
    count_d  = count_q;
    words_d  = words_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;

    case (state_q)
      IDLE, ERROR: begin
        if (accept && bus.in_byte == SYNC_BYTE) begin
          state_d  = COUNT;
          chk_d    = '0;
          pk_clear = 1'b1;
        end
      end

      COUNT: begin
        if (accept) begin
          if (bus.in_byte == 8'd0 || bus.in_byte > 8'(MAX_WORDS)) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
            count_d = bus.in_byte[6:0];
            words_d = '0;
            addr_d  = '0;
            chk_d   = chk_q ^ bus.in_byte;
          end
        end
      end

      DATA: begin
        if (accept) begin
          pk_shift = 1'b1;
          chk_d    = chk_q ^ bus.in_byte;
          if (pk_done) state_d = WRITE;
        end
      end

      // The increment past the last word may wrap; nothing reads it afterwards.
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        words_d = words_q + 7'd1;
        state_d = (words_q + 7'd1 == count_q) ? CHECK : DATA;
      end

      CHECK: begin
        if (accept) state_d = (bus.in_byte == chk_q) ? RUN : ERROR;
      end

      RUN: state_d = RUN;

      default: state_d = IDLE;
    endcase

    run_d  = (state_d == RUN);
    err_d  = (state_d == ERROR);
    busy_d = is_busy(state_d);
    wen_d  = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      chk_q   <= '0;
      count_q <= '0;
      words_q <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      chk_q   <= chk_d;
      count_q <= count_d;
      words_q <= words_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
    end
  end

  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = DATA_W'(pk_word);
  assign cpu_run       = run_q;
  assign load_busy     = busy_q;
  assign load_error    = err_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed frames push expected memory
// writes, a negedge monitor pops and compares every mem_wen pulse.
module tb_program_loader;
  import loader_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       cpu_run;
  logic       load_busy;
  logic       load_error;
  logic [6:0] words_loaded;

  program_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  program_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .bus          (bus),
    .cpu_run      (cpu_run),
    .load_busy    (load_busy),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks   = 0;
  int   failures = 0;
  int   negCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write, land in
  // the cycle right after its fourth byte, and hold in_ready low.
  always @(negedge clk) begin
    negCount++;
    if (clr && bus.mem_wen) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wr_addr", 32'(bus.mem_addr), 32'(monE.addr));
        checkOutput("wr_data", bus.mem_data, monE.data);
        checkOutput("wr_cycle", 32'(negCount), 32'(monE.cyc));
        checkOutput("wr_in_ready", 32'(bus.in_ready), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    #1;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL handshake_timeout: byte 0x%0h got in_ready=0 expected 1", b);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input logic [7:0] addr);
    exp_t e;
    for (int i = 0; i < 4; i++) applyStimulus(w[31-8*i -: 8]);
    e.addr = addr;
    e.data = w;
    e.cyc  = negCount + 1;
    expQ.push_back(e);
  endtask

  task automatic idleBus();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic doReset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    expQ.delete();
  endtask

  task automatic checkStatus(input string tag, input logic run, input logic err,
                             input logic busy);
    checkOutput({tag, "_cpu_run"}, 32'(cpu_run), 32'(run));
    checkOutput({tag, "_load_error"}, 32'(load_error), 32'(err));
    checkOutput({tag, "_load_busy"}, 32'(load_busy), 32'(busy));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // Reset values.
    #2;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);
    checkStatus("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Single word frame.
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    sendWord(32'h12345678, 8'h00);
    #1;
    checkStatus("t1_pre_chk", 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h09);
    idleBus();
    checkStatus("t1_done", 1'b1, 1'b0, 1'b0);
    checkOutput("t1_words", 32'(words_loaded), 32'd1);
    checkOutput("t1_run_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t1_queue_empty", 32'(expQ.size()), 32'd0);

    // Junk before the sync byte is ignored.
    doReset();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    idleBus();
    checkStatus("t2_junk", 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    sendWord(32'hDEADBEEF, 8'h00);
    applyStimulus(8'h23);
    idleBus();
    checkStatus("t2_done", 1'b1, 1'b0, 1'b0);
    checkOutput("t2_queue_empty", 32'(expQ.size()), 32'd0);

    // Illegal counts.
    doReset();
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    idleBus();
    checkStatus("t3_cnt0", 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hA5);
    #1;
    checkStatus("t3_resync", 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h41);
    idleBus();
    checkStatus("t3_cnt41", 1'b0, 1'b1, 1'b0);
    checkOutput("t3_err_in_ready", 32'(bus.in_ready), 32'd1);

    // Full capacity, valid held high; checksum is 0x40 ^ xor(0..255) = 0x40.
    doReset();
    applyStimulus(8'hA5);
    applyStimulus(8'h40);
    for (int i = 0; i < 64; i++) begin
      sendWord({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 8'(4*i));
    end
    applyStimulus(8'h40);
    idleBus();
    checkStatus("t4_done", 1'b1, 1'b0, 1'b0);
    checkOutput("t4_words", 32'(words_loaded), 32'd64);
    checkOutput("t4_queue_empty", 32'(expQ.size()), 32'd0);

    // Bad checksum, then a good frame recovers.
    doReset();
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    sendWord(32'h12345678, 8'h00);
    applyStimulus(8'h08);
    idleBus();
    checkStatus("t5_bad_chk", 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    sendWord(32'hDEADBEEF, 8'h00);
    applyStimulus(8'h23);
    idleBus();
    checkStatus("t5_recover", 1'b1, 1'b0, 1'b0);
    checkOutput("t5_queue_empty", 32'(expQ.size()), 32'd0);

    // Asynchronous reset in the middle of DATA.
    doReset();
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    sendWord(32'h11223344, 8'h00);
    applyStimulus(8'h55);
    #3;
    checkOutput("t6_busy_before", 32'(load_busy), 32'd1);
    bus.in_valid = 1'b0;
    clr = 1'b0;
    #1;
    checkOutput("t6_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("t6_mem_data", bus.mem_data, 32'd0);
    checkOutput("t6_mem_wen", 32'(bus.mem_wen), 32'd0);
    checkOutput("t6_words", 32'(words_loaded), 32'd0);
    checkOutput("t6_in_ready", 32'(bus.in_ready), 32'd0);
    checkStatus("t6_rst", 1'b0, 1'b0, 1'b0);
    checkOutput("t6_queue_empty", 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    checkOutput("t6_idle_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    sendWord(32'hCAFEBABE, 8'h00);
    applyStimulus(8'h31);
    idleBus();
    checkStatus("t6_reload", 1'b1, 1'b0, 1'b0);
    checkOutput("t6_reload_words", 32'(words_loaded), 32'd1);
    checkOutput("t6_reload_queue", 32'(expQ.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Front-end stage directly upstream of the instruction memory unit and the processor reset.
- Receives a framed byte stream over a valid/ready handshake and packs bytes into 32-bit instruction words.
- Writes the words to sequential instruction-memory word addresses, then checks a checksum.
- On success, releases the single-cycle processor by asserting cpu_run; this drives the processor's clear.

Parameters:
- ADDR_W, 8, instruction memory byte-address width; matches the PC width.
- DATA_W, 32, instruction word width.
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_WORDS, 64, capacity in words (2^ADDR_W / 4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-low (0 = reset).
- in_valid  input  1  upstream byte valid.
- in_byte  input  8  upstream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_wen  output  1  instruction memory write enable; one-cycle pulse per word.
- mem_addr  output  ADDR_W  byte address of the word being written.
- mem_data  output  DATA_W  word being written.
- cpu_run  output  1  processor released; 1 = run, 0 = hold in clear.
- load_busy  output  1  a frame is in progress.
- load_error  output  1  the last frame was rejected.
- words_loaded  output  7  number of words written in the current or last frame.

Behaviour:
- Handshake and reset
  - A byte is accepted when in_valid & in_ready are both high at a rising edge.
  - Upstream holds in_byte stable while in_valid=1 and in_ready=0.
  - While clr=0, all outputs are forced to 0 asynchronously, state goes to IDLE, the address counter is 0 and the checksum is 0.
  - Reset asserted mid-frame aborts the frame. Memory contents already written stay in memory.
- Frame format: SYNC_BYTE, COUNT (N words, 1..64), 4*N data bytes, CHK.
  - Data bytes are big-endian: the first byte of each group goes to [31:24].
  - CHK = XOR of COUNT and all data bytes.
- States
  - IDLE: in_ready=1.
    - SYNC_BYTE -> COUNT and clear the checksum.
    - Any other byte is discarded.
  - COUNT: in_ready=1.
    - Byte of 0 or >MAX_WORDS -> ERROR.
    - Otherwise latch N, set words_loaded=0, set address=0 and go to DATA.
  - DATA: in_ready=1. Shift each accepted byte into the packer and fold it into the checksum.
    - On the 4th byte of a group -> WRITE.
  - WRITE: lasts one cycle.
    - in_ready=0, mem_wen=1, mem_addr=current address, mem_data=packed word.
    - The write occurs exactly one cycle after the 4th byte is accepted.
    - Next edge: address += 4 and words_loaded += 1.
    - Go to CHECK if words_loaded+1 == N, otherwise DATA.
  - CHECK: in_ready=1.
    - Accepted byte == checksum -> RUN.
    - Accepted byte != checksum -> ERROR.
  - RUN: cpu_run=1 from the cycle after CHK is accepted. in_ready=0.
    - The only exit is reset.
  - ERROR: load_error=1 and cpu_run=0. in_ready=1.
    - SYNC_BYTE -> COUNT, clear load_error and restart the frame.
    - Other bytes are discarded.
- Output rules
  - load_busy=1 in COUNT, DATA, WRITE and CHECK.
  - mem_wen is never high outside WRITE.
- Address rules
  - The address never wraps within a frame. With N=64 the last write is at 0xFC.
  - The address increment after the final write is don't-care.
- All outputs are registered except in_ready, which is decoded from state.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, COUNT, DATA, WRITE, CHECK, RUN, ERROR);
  - the SYNC_BYTE and MAX_WORDS constants;
  - the word type logic [31:0].
- Sub-module byte_packer: 4-byte shift register with a 2-bit byte counter. It produces word and word_done; the FSM clears it on entry to COUNT.

Test Plan:
- Reset, then send A5,01,12,34,56,78,09 -> one mem_wen pulse with addr 0x00 and data 0x12345678, one cycle after byte 78. cpu_run=1 the cycle after 09 is accepted; words_loaded=1, load_error=0.
- Send 00,FF,3C before A5,01,DE,AD,BE,EF,chk -> the leading bytes are ignored with no mem_wen. The single write is 0xDEADBEEF at 0x00.
- COUNT=0x00, and separately COUNT=0x41 -> ERROR; load_error=1, no mem_wen, cpu_run=0.
- Full 64-word frame with in_valid held high -> 64 writes at 0x00..0xFC in order; in_ready=0 on every WRITE cycle and no byte is lost. words_loaded=64, then cpu_run=1.
- Frame with CHK off by one bit -> ERROR, cpu_run=0. A following correct frame starting with A5 -> load_error clears and the run is released.
- Assert clr=0 mid-DATA, asynchronously between edges -> all outputs 0 immediately. After release the state is IDLE; a new complete frame loads from address 0x00.
